// File: rtl/spi_burst_sequencer.sv
// Burst sequencer feeding the epRISC SPI peripheral's register bus from a host TX FIFO, collecting replies in an RX FIFO.
// Define SPI_SEQ_TIMEOUT_EN to bound the busy-poll (WAIT) state by TIMEOUT_CYCLES.
module spi_burst_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [1:0]  iHostAddr,
    input  logic [15:0] iHostData,
    output logic [15:0] oHostData,
    input  logic        iHostWrite,
    input  logic        iHostEnable,
    output logic        oInt,
    output logic [1:0]  oSpiAddr,
    output logic [15:0] oSpiData,
    input  logic [15:0] iSpiData,
    output logic        oSpiWrite,
    output logic        oSpiEnable
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("FIFO_DEPTH must be a power of 2 in 2..64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must fit the 16-bit poll counter");
    end

    typedef enum logic [2:0] {
        stIdle, stLoad, stGo, stWait, stRead, stRelease
    } stateT;

    stateT state, stateNext;

    logic [7:0]    txMem [FIFO_DEPTH];
    logic [PW-1:0] txWrPtr, txRdPtr;
    logic [CW-1:0] txCount;
    logic [7:0]    rxMem [FIFO_DEPTH];
    logic [PW-1:0] rxWrPtr, rxRdPtr;
    logic [CW-1:0] rxCount;

    logic [5:0]  ctrl;
    logic [3:0]  ssl;
    logic        done, ovf, toErr;
    logic        timeoutHit;
    logic [15:0] hostRdData;

    logic hostWr, hostRd, ctrlWr;
    logic txEmpty, txFull, txPush, txDrop, txPop;
    logic rxEmpty, rxFull, rxPush, rxDrop, rxPop;
    logic burstStart;

    assign hostWr  = iHostEnable & iHostWrite;
    assign hostRd  = iHostEnable & ~iHostWrite;
    assign ctrlWr  = hostWr && iHostAddr == 2'd0;

    assign txEmpty = txCount == '0;
    assign txFull  = txCount == CW'(FIFO_DEPTH);
    assign txPush  = hostWr && iHostAddr == 2'd1 && !txFull;
    assign txDrop  = hostWr && iHostAddr == 2'd1 && txFull;
    assign txPop   = state == stLoad;

    assign rxEmpty = rxCount == '0;
    assign rxFull  = rxCount == CW'(FIFO_DEPTH);
    assign rxPush  = state == stRead && !rxFull;
    assign rxDrop  = state == stRead && rxFull;
    assign rxPop   = hostRd && iHostAddr == 2'd1 && !rxEmpty;

    assign burstStart = state == stIdle && stateNext == stLoad;

    // Only bits 7 of the SPI status word and the CTRL fields below are meaningful here.
    logic unusedBits;
    assign unusedBits = &{1'b0, iSpiData[15:8], iHostData[13:6]};

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] toCount;
    logic [15:0] toNext;
    assign toNext = toCount + 16'd1;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            toCount <= '0;
            toErr   <= 1'b0;
        end else begin
            toCount <= (state == stWait) ? toNext : 16'd0;
            if (timeoutHit)
                toErr <= 1'b1;
            else if (ctrlWr && iHostData[13])
                toErr <= 1'b0;
        end
    end
`else
    assign toErr = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (!iRst)
            state <= stIdle;
        else
            state <= stateNext;
    end

    // NOTE: every output of this block is assigned a default first so no path can infer a latch.
    always_comb begin
        stateNext  = state;
        timeoutHit = 1'b0;
        oSpiEnable = 1'b1;
        oSpiWrite  = 1'b0;
        oSpiAddr   = 2'd0;
        oSpiData   = 16'h0000;
        case (state)
            stIdle: begin
                oSpiEnable = 1'b0;
                if (ctrl[4] && !txEmpty)
                    stateNext = stLoad;
            end
            stLoad: begin
                oSpiAddr  = 2'd1;
                oSpiWrite = 1'b1;
                oSpiData  = {8'h00, txMem[txRdPtr]};
                stateNext = stGo;
            end
            stGo: begin
                oSpiWrite = 1'b1;
                oSpiData  = {9'h000, ssl, 3'b000} | 16'h0080;
                stateNext = stWait;
            end
            stWait: begin
                if (!iSpiData[7])
                    stateNext = stRead;
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (toNext == 16'(TIMEOUT_CYCLES)) begin
                    stateNext  = stRelease;
                    timeoutHit = 1'b1;
                end
`endif
            end
            stRead: begin
                oSpiAddr  = 2'd2;
                stateNext = (ctrl[4] && !txEmpty) ? stLoad : stRelease;
            end
            stRelease: begin
                oSpiWrite = 1'b1;
                stateNext = stIdle;
            end
            default: stateNext = stIdle;
        endcase
    end

    // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
    always_ff @(posedge iClk) begin
        if (txPush)
            txMem[txWrPtr] <= iHostData[7:0];
        if (rxPush)
            rxMem[rxWrPtr] <= iSpiData[7:0];
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            txWrPtr <= '0;
            txRdPtr <= '0;
            txCount <= '0;
        end else begin
            if (txPush)
                txWrPtr <= txWrPtr + 1'b1;
            if (timeoutHit) begin
                // Flush discards whatever is queued; a same-cycle push survives as the new head.
                txRdPtr <= txWrPtr;
                txCount <= CW'(txPush);
            end else begin
                if (txPop)
                    txRdPtr <= txRdPtr + 1'b1;
                if (txPush && !txPop)
                    txCount <= txCount + 1'b1;
                else if (txPop && !txPush)
                    txCount <= txCount - 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
        end else begin
            if (rxPush)
                rxWrPtr <= rxWrPtr + 1'b1;
            if (rxPop)
                rxRdPtr <= rxRdPtr + 1'b1;
            if (rxPush && !rxPop)
                rxCount <= rxCount + 1'b1;
            else if (rxPop && !rxPush)
                rxCount <= rxCount - 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            ctrl <= '0;
            ssl  <= '0;
            done <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (ctrlWr)
                ctrl <= iHostData[5:0];
            if (burstStart)
                ssl <= ctrl[3:0];
            // Sequencer set takes priority over a same-cycle host clear.
            if (state == stRelease)
                done <= 1'b1;
            else if (ctrlWr && iHostData[14])
                done <= 1'b0;
            if (txDrop || rxDrop)
                ovf <= 1'b1;
            else if (ctrlWr && iHostData[15])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        hostRdData = 16'h0000;
        case (iHostAddr)
            2'd0: hostRdData = {ovf, done, toErr, rxFull, rxEmpty, txFull, txEmpty,
                                state != stIdle, 2'b00, ctrl};
            2'd1: hostRdData = rxEmpty ? 16'h0000 : {8'h00, rxMem[rxRdPtr]};
            2'd2: hostRdData = {8'(txCount), 8'(rxCount)};
            2'd3: hostRdData = 16'h0001;
            default: hostRdData = 16'h0000;
        endcase
    end

    assign oHostData = iHostEnable ? hostRdData : 16'hzzzz;
    assign oInt      = done & ctrl[5];

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Scoreboard bench for spi_burst_sequencer: expected SPI bus cycles and host reads are queued
// by the stimulus and checked by a monitor on the falling edge.
module tb_spi_burst_sequencer;
    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic [1:0]  iHostAddr = 2'd0;
    logic [15:0] iHostData = 16'h0000;
    wire  [15:0] oHostData;
    logic        iHostWrite = 1'b0;
    logic        iHostEnable = 1'b0;
    logic        oInt;
    logic [1:0]  oSpiAddr;
    logic [15:0] oSpiData;
    logic [15:0] iSpiData;
    logic        oSpiWrite;
    logic        oSpiEnable;

    always #5 iClk = ~iClk;

    spi_burst_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
        .iClk(iClk), .iRst(iRst),
        .iHostAddr(iHostAddr), .iHostData(iHostData), .oHostData(oHostData),
        .iHostWrite(iHostWrite), .iHostEnable(iHostEnable), .oInt(oInt),
        .oSpiAddr(oSpiAddr), .oSpiData(oSpiData), .iSpiData(iSpiData),
        .oSpiWrite(oSpiWrite), .oSpiEnable(oSpiEnable)
    );

    int passCount = 0;
    int totalCount = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        else
            passCount++;
    endtask

    // SPI peripheral model: busy for busyCfg status polls after each GO, replies lastTx ^ xorMask.
    int         busyCfg = 0;
    int         busyLeft = 0;
    logic [7:0] xorMask = 8'h00;
    logic       stuck = 1'b0;
    logic [7:0] lastTx = 8'h00;

    always @(posedge iClk) begin
        if (oSpiEnable && oSpiWrite && oSpiAddr == 2'd1)
            lastTx <= oSpiData[7:0];
        if (oSpiEnable && oSpiWrite && oSpiAddr == 2'd0 && oSpiData[7])
            busyLeft <= busyCfg;
        else if (oSpiEnable && !oSpiWrite && oSpiAddr == 2'd0 && busyLeft > 0)
            busyLeft <= busyLeft - 1;
    end

    always_comb begin
        iSpiData = 16'h0000;
        if (oSpiAddr == 2'd0)
            iSpiData[7] = stuck || (busyLeft != 0);
        else if (oSpiAddr == 2'd2)
            iSpiData[7:0] = lastTx ^ xorMask;
    end

    logic [31:0] spiQ[$];
    logic [15:0] hostQ[$];

    function automatic logic [31:0] busWord(input logic [1:0] a, input logic w, input logic [15:0] d);
        return {13'h0, a, w, w ? d : 16'h0000};
    endfunction

    always @(negedge iClk) begin
        if (iRst && oSpiEnable) begin
            if (spiQ.size() == 0)
                check("spi_unexpected", busWord(oSpiAddr, oSpiWrite, oSpiData), 32'hFFFF_FFFF);
            else
                check("spi_bus", busWord(oSpiAddr, oSpiWrite, oSpiData), spiQ.pop_front());
        end
        if (iRst && iHostEnable && !iHostWrite) begin
            if (hostQ.size() == 0)
                check("host_unexpected", {16'h0, oHostData}, 32'hFFFF_FFFF);
            else
                check("host_read", {16'h0, oHostData}, {16'h0, hostQ.pop_front()});
        end
    end

    task automatic hostWr(input logic [1:0] a, input logic [15:0] d);
        iHostEnable = 1'b1; iHostWrite = 1'b1; iHostAddr = a; iHostData = d;
        @(posedge iClk); #1;
        iHostEnable = 1'b0; iHostWrite = 1'b0;
    endtask

    task automatic hostRd(input logic [1:0] a, input logic [15:0] exp);
        hostQ.push_back(exp);
        iHostEnable = 1'b1; iHostWrite = 1'b0; iHostAddr = a;
        @(posedge iClk); #1;
        iHostEnable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    // One byte: LOAD, GO, (busy+1) status polls, READ.
    task automatic expectByte(input logic [7:0] b, input logic [15:0] goWord, input int polls);
        spiQ.push_back(busWord(2'd1, 1'b1, {8'h00, b}));
        spiQ.push_back(busWord(2'd0, 1'b1, goWord));
        for (int i = 0; i < polls; i++)
            spiQ.push_back(busWord(2'd0, 1'b0, 16'h0000));
        spiQ.push_back(busWord(2'd2, 1'b0, 16'h0000));
    endtask

    task automatic expectRelease();
        spiQ.push_back(busWord(2'd0, 1'b1, 16'h0000));
    endtask

    task automatic waitDone();
        for (int i = 0; i < 600; i++) begin
            if (spiQ.size() == 0 && !oSpiEnable)
                break;
            @(posedge iClk); #1;
        end
        check("burst_end", {oSpiEnable, 31'(spiQ.size())}, 32'h0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge iClk);
        #1;
        check("rst_int", {31'h0, oInt}, 32'h0);
        check("rst_spi_en", {31'h0, oSpiEnable}, 32'h0);
        check("rst_spi_bus", {14'h0, oSpiAddr, oSpiData}, 32'h0);
        iRst = 1'b1;
        hostRd(2'd0, 16'h0A00);
        hostRd(2'd2, 16'h0000);
        hostWr(2'd3, 16'hFFFF);
        hostRd(2'd3, 16'h0001);
        hostRd(2'd0, 16'h0A00);

        // Single byte, reply 0xA5 ^ 0x99 = 0x3C
        busyCfg = 0; xorMask = 8'h99;
        expectByte(8'hA5, 16'h0088, 1);
        expectRelease();
        hostWr(2'd1, 16'h00A5);
        hostWr(2'd0, 16'h0031);
        waitDone();
        check("t1_int", {31'h0, oInt}, 32'h1);
        hostRd(2'd0, 16'h4231);
        hostRd(2'd1, 16'h003C);
        hostRd(2'd1, 16'h0000);
        hostWr(2'd0, 16'h4000);
        check("t1_int_clr", {31'h0, oInt}, 32'h0);

        // Three-byte burst, SS=2, two busy polls per byte, echo
        busyCfg = 2; xorMask = 8'h00;
        expectByte(8'h01, 16'h0090, 3);
        expectByte(8'h02, 16'h0090, 3);
        expectByte(8'h03, 16'h0090, 3);
        expectRelease();
        hostWr(2'd1, 16'h0001);
        hostWr(2'd1, 16'h0002);
        hostWr(2'd1, 16'h0003);
        hostWr(2'd0, 16'h0032);
        waitDone();
        check("t2_int", {31'h0, oInt}, 32'h1);
        hostRd(2'd2, 16'h0003);
        hostRd(2'd1, 16'h0001);
        hostRd(2'd1, 16'h0002);
        hostRd(2'd1, 16'h0003);
        hostWr(2'd0, 16'h4000);
        check("t2_int_clr", {31'h0, oInt}, 32'h0);
        hostRd(2'd0, 16'h0A00);

        // TX overflow with RUN=0: ninth push dropped
        busyCfg = 0;
        for (int i = 0; i < 9; i++)
            hostWr(2'd1, 16'h0010 + 16'(i));
        hostRd(2'd2, 16'h0800);
        hostRd(2'd0, 16'h8C00);
        hostWr(2'd0, 16'h8000);
        hostRd(2'd0, 16'h0C00);

        // RX full: nine bytes, no host reads; reply b ^ 0x0F, ninth reply dropped
        xorMask = 8'h0F;
        for (int i = 0; i < 9; i++)
            expectByte(8'h10 + 8'(i), 16'h00A0, 1);
        expectRelease();
        hostWr(2'd0, 16'h0014);
        idle(3);
        hostWr(2'd1, 16'h0018);
        waitDone();
        hostRd(2'd0, 16'hD214);
        hostRd(2'd2, 16'h0008);
        for (int i = 0; i < 8; i++)
            hostRd(2'd1, 16'h001F - 16'(i));
        hostRd(2'd1, 16'h0000);
        hostWr(2'd0, 16'hC000);
        hostRd(2'd0, 16'h0A00);

        // RUN cleared mid-byte: finish byte, release; new SS applies to the next burst
        busyCfg = 10; xorMask = 8'h00;
        expectByte(8'h55, 16'h0088, 11);
        expectRelease();
        hostWr(2'd1, 16'h0055);
        hostWr(2'd1, 16'h0066);
        hostWr(2'd1, 16'h0077);
        hostWr(2'd0, 16'h0011);
        idle(4);
        hostWr(2'd0, 16'h0008);
        waitDone();
        hostRd(2'd2, 16'h0201);
        hostRd(2'd0, 16'h4008);
        busyCfg = 0;
        expectByte(8'h66, 16'h00C0, 1);
        expectByte(8'h77, 16'h00C0, 1);
        expectRelease();
        hostWr(2'd0, 16'h4018);
        waitDone();
        hostRd(2'd1, 16'h0055);
        hostRd(2'd1, 16'h0066);
        hostRd(2'd1, 16'h0077);
        hostWr(2'd0, 16'h4000);
        hostRd(2'd0, 16'h0A00);

`ifdef SPI_SEQ_TIMEOUT_EN
        // Stuck busy: 16 polls, then release with TX flushed and TOERR set
        stuck = 1'b1;
        spiQ.push_back(busWord(2'd1, 1'b1, 16'h00AA));
        spiQ.push_back(busWord(2'd0, 1'b1, 16'h0088));
        for (int i = 0; i < 16; i++)
            spiQ.push_back(busWord(2'd0, 1'b0, 16'h0000));
        expectRelease();
        hostWr(2'd1, 16'h00AA);
        hostWr(2'd1, 16'h00BB);
        hostWr(2'd0, 16'h0031);
        waitDone();
        check("to_int", {31'h0, oInt}, 32'h1);
        hostRd(2'd0, 16'h6A31);
        hostRd(2'd2, 16'h0000);
        hostWr(2'd0, 16'h6000);
        hostRd(2'd0, 16'h0A00);
        stuck = 1'b0;
`endif

        idle(2);
        check("spi_q_drained", 32'(spiQ.size()), 32'h0);
        check("host_q_drained", 32'(hostQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- Upstream feeder for the epRISC SPI peripheral. Host CPU queues bytes into a TX FIFO. The sequencer drives the SPI peripheral's 2-bit register bus, one byte per transfer, for each queued byte.
- Received bytes are collected in an RX FIFO. Chip select is held for the whole burst and released when the TX FIFO drains.
- A completion interrupt is raised at burst end.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO (power of 2, 2..64)
- TIMEOUT_CYCLES, 4096, poll limit per byte (only used with SPI_SEQ_TIMEOUT_EN)

Ports:
- iClk in 1 system clock, all logic on rising edge
- iRst in 1 synchronous active-low reset (0 = reset, sampled on iClk rising edge)
- iHostAddr in 2 host register select
- iHostData in 16 host write data
- oHostData out 16 host read data, high-Z when iHostEnable=0
- iHostWrite in 1 host write strobe
- iHostEnable in 1 host select
- oInt out 1 done interrupt, level
- oSpiAddr out 2 to SPI iAddr
- oSpiData out 16 to SPI iData
- iSpiData in 16 from SPI oData
- oSpiWrite out 1 to SPI iWrite
- oSpiEnable out 1 to SPI iEnable

Behaviour:
- Reset. All outputs and state are cleared:
  - oInt=0, oSpiEnable=0, oSpiWrite=0, oSpiAddr=0, oSpiData=0.
  - FIFOs emptied, CTRL=0, state IDLE.
  - Reset mid-burst aborts immediately. The SPI peripheral is reset separately by the system.
- Host reg 0 (CTRL/STATUS).
  - Write: [3:0] SS mask, [4] RUN, [5] IRQEN.
  - Write-1-to-clear: [14] DONE, [15] OVF.
  - Read: [5:0] as written, [8] BUSY (state!=IDLE), [9] TXEMPTY, [10] TXFULL, [11] RXEMPTY, [12] RXFULL, [13] TOERR, [14] DONE, [15] OVF.
- Host reg 1.
  - Write pushes iHostData[7:0] to TX. If TX is full, the byte is dropped and OVF is set.
  - Read returns {8'h0, RX head} and pops on that cycle. If RX is empty, the read returns 0 and nothing pops.
- Host reg 2 read: {TX count[7:0], RX count[7:0]}.
- Host reg 3 read: 16'h0001. Writes are ignored.
- Same-cycle host push and sequencer pop on TX both take effect; the count is unchanged. The same applies to RX.
- SS mask is latched at burst start into SSL. CTRL writes during a burst affect the next burst only.
- SPI-side outputs are decoded combinationally from state. oSpiEnable=1 in every state except IDLE.
- State machine:
  - IDLE: if RUN=1 and TX not empty, go to LOAD and latch SSL.
  - LOAD: drive addr 1, write, data={8'h0, TX head}; pop TX. Go to GO.
  - GO: drive addr 0, write, data={9'h0, SSL, 3'b0} | 16'h0080. Go to WAIT.
  - WAIT: drive addr 0, read. Sample iSpiData[7] at the edge. If 0, go to READ; otherwise stay.
  - READ: drive addr 2, read. Push iSpiData[7:0] to RX. If RX is full, drop the byte and set OVF.
    - Next state is LOAD if RUN=1 and TX not empty; otherwise RELEASE.
  - RELEASE: drive addr 0, write, data=0 (deasserts SS). Set DONE. Go to IDLE.
- Per-byte host-clock overhead is 3 cycles plus WAIT duration. WAIT lasts at least 1 cycle.
- Clearing RUN mid-burst finishes the current byte, then goes to RELEASE.
- oInt = DONE & IRQEN. DONE is sticky until cleared by writing 1 to bit 14.
- If a host DONE-clear and a sequencer DONE-set occur in the same cycle, set wins. Same rule for OVF.
- FIFO pointers wrap modulo FIFO_DEPTH. Counts span 0..FIFO_DEPTH, so full = FIFO_DEPTH.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter is cleared on entering WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES, go to RELEASE, flush TX, and set TOERR (sticky).
  - TOERR is cleared by writing CTRL with bit 13 = 1.
  - DONE is still set on RELEASE.
- Disabled: WAIT is unbounded, no counter is present, and TOERR reads 0.

Test Plan:
- Reset with iRst=0 for 2 cycles: oInt=0, oSpiEnable=0, reg 0 reads 16'h0A00 (TXEMPTY, RXEMPTY), reg 2 reads 0.
- Single byte, 1-cycle SPI busy: push 0xA5, CTRL=0x0031.
  - SPI bus sequence: wr addr1 0x00A5; wr addr0 0x0088; rd addr0; rd addr2; wr addr0 0x0000.
  - Model returns 0x3C: RX pops 0x003C, DONE=1, oInt=1.
- Three-byte burst 0x01,0x02,0x03, SS=0x2: SS write 0x0090 repeats per byte with no zero-write until after the third READ. RX yields echoed bytes in order. Write 0x4000 to reg 0 deasserts oInt.
- Overflow: FIFO_DEPTH=8, push 9 bytes with RUN=0: reg 2 = 0x0800, OVF=1. Write 0x8000 clears OVF.
- RX full: run 9 bytes without host reads: ninth received byte dropped, OVF=1, RX count=8, DONE=1.
- Timeout (SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): SPI model holds bit7=1. After 16 WAIT cycles: wr addr0 0x0000, TOERR=1, TX empty, BUSY=0.
